// File: rtl/dm_ctrl_if.sv
// rtl/dm_ctrl_if.sv - request/response bundle between the MEM stage and dm_ctrl
interface dm_ctrl_if #(
   parameter int AW = 32
);
   logic          req_valid;
   logic          req_ready;
   logic [2:0]    req_op;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic [31:0]   req_pc;
   logic          rsp_valid;
   logic [31:0]   rsp_data;
   logic          rsp_exc;
   logic          st_exc;
   logic          init_done;

   modport master (
      output req_valid, req_op, req_addr, req_wdata, req_pc,
      input  req_ready, rsp_valid, rsp_data, rsp_exc, st_exc, init_done
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, req_pc,
      output req_ready, rsp_valid, rsp_data, rsp_exc, st_exc, init_done
   );
endinterface

// File: rtl/dm_ctrl.sv
// rtl/dm_ctrl.sv - MIPS data-memory controller: byte-lane stores, extended loads, zero-fill sweep
// Optional store trace printing is compiled in with DM_DISPLAY_EN.
module dm_ctrl #(
   parameter int DEPTH  = 4096,
   parameter int AW     = 32,
   parameter int RD_LAT = 1
) (
   input  logic     clk,
   input  logic     reset,
   dm_ctrl_if.slave bus
);
   localparam int            CW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);
   localparam logic [CW-1:0] LAST_W  = CW'(DEPTH - 1);

   localparam logic [2:0] OP_LW  = 3'd0;
   localparam logic [2:0] OP_LH  = 3'd1;
   localparam logic [2:0] OP_LHU = 3'd2;
   localparam logic [2:0] OP_LB  = 3'd3;
   localparam logic [2:0] OP_LBU = 3'd4;
   localparam logic [2:0] OP_SW  = 3'd5;
   localparam logic [2:0] OP_SH  = 3'd6;
   localparam logic [2:0] OP_SB  = 3'd7;

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic          w_ready, w_init_done;

   logic [31:0]   r_mem [DEPTH];

   logic [AW-1:0] w_addr;
   logic [1:0]    w_bsel;
   logic [CW-1:0] w_idx;
   logic          w_range_err, w_align_err, w_err;
   logic          w_is_store, w_accept, w_st_commit, w_st_bad, w_ld_go;
   logic [3:0]    w_be;
   logic [31:0]   w_st_data;

   logic          w_wr_en;
   logic [CW-1:0] w_wr_idx;
   logic [3:0]    w_wr_be;
   logic [31:0]   w_wr_data;

   logic          r_v1, r_exc1, r_st_exc;
   logic [2:0]    r_op1;
   logic [1:0]    r_bsel1;
   logic [31:0]   r_rd1;

   logic          w_fv, w_fexc;
   logic [2:0]    w_fop;
   logic [1:0]    w_fbsel;
   logic [31:0]   w_fword;
   logic [7:0]    w_lane_b;
   logic [15:0]   w_lane_h;
   logic [31:0]   w_ext;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_INIT;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_init_done = 1'b0;
      case (r_state)
         S_INIT: if (r_cnt == LAST_W) w_state_nxt = S_RUN;
         S_RUN: begin
            w_ready     = 1'b1;
            w_init_done = 1'b1;
         end
         default: w_state_nxt = S_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)                 r_cnt <= '0;
      else if (r_state == S_INIT) r_cnt <= (r_cnt == LAST_W) ? '0 : r_cnt + 1'b1;
   end

   assign w_addr      = bus.req_addr;
   assign w_bsel      = w_addr[1:0];
   assign w_idx       = w_addr[CW+1:2];
   assign w_range_err = ({2'b00, w_addr[AW-1:2]} >= DEPTH_W);
   assign w_is_store  = (bus.req_op >= OP_SW);

   always_comb begin
      w_align_err = 1'b0;
      case (bus.req_op)
         OP_LW, OP_SW:         w_align_err = (w_bsel != 2'b00);
         OP_LH, OP_LHU, OP_SH: w_align_err = w_bsel[0];
         default:              w_align_err = 1'b0;
      endcase
   end

   assign w_err       = w_range_err | w_align_err;
   // A request coinciding with a reset edge is discarded entirely.
   assign w_accept    = bus.req_valid & w_ready & ~reset;
   assign w_st_commit = w_accept & w_is_store & ~w_err;
   assign w_st_bad    = w_accept & w_is_store & w_err;
   assign w_ld_go     = w_accept & ~w_is_store;

   always_comb begin
      w_be      = 4'b0000;
      w_st_data = bus.req_wdata;
      case (bus.req_op)
         OP_SW: w_be = 4'b1111;
         OP_SH: begin
            w_be      = w_bsel[1] ? 4'b1100 : 4'b0011;
            w_st_data = {2{bus.req_wdata[15:0]}};
         end
         OP_SB: begin
            w_be      = 4'b0001 << w_bsel;
            w_st_data = {4{bus.req_wdata[7:0]}};
         end
         default: w_be = 4'b0000;
      endcase
   end

   always_comb begin
      w_wr_en   = w_st_commit;
      w_wr_idx  = w_idx;
      w_wr_be   = w_be;
      w_wr_data = w_st_data;
      if (r_state == S_INIT && !reset) begin
         w_wr_en   = 1'b1;
         w_wr_idx  = r_cnt;
         w_wr_be   = 4'b1111;
         w_wr_data = 32'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (w_wr_be[b]) r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_ld_go && !w_err) r_rd1 <= r_mem[w_idx];
      if (w_ld_go) begin
         r_op1   <= bus.req_op;
         r_bsel1 <= w_bsel;
         r_exc1  <= w_err;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_v1     <= 1'b0;
         r_st_exc <= 1'b0;
      end else begin
         r_v1     <= w_ld_go;
         r_st_exc <= w_st_bad;
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic        r_v2, r_exc2;
         logic [2:0]  r_op2;
         logic [1:0]  r_bsel2;
         logic [31:0] r_rd2;

         always_ff @(posedge clk) begin
            if (reset) r_v2 <= 1'b0;
            else       r_v2 <= r_v1;
            r_exc2  <= r_exc1;
            r_op2   <= r_op1;
            r_bsel2 <= r_bsel1;
            r_rd2   <= r_rd1;
         end

         assign w_fv    = r_v2;
         assign w_fexc  = r_exc2;
         assign w_fop   = r_op2;
         assign w_fbsel = r_bsel2;
         assign w_fword = r_rd2;
      end else begin : g_lat1
         assign w_fv    = r_v1;
         assign w_fexc  = r_exc1;
         assign w_fop   = r_op1;
         assign w_fbsel = r_bsel1;
         assign w_fword = r_rd1;
      end
   endgenerate

   assign w_lane_b = w_fword[{w_fbsel, 3'b000} +: 8];
   assign w_lane_h = w_fbsel[1] ? w_fword[31:16] : w_fword[15:0];

   always_comb begin
      w_ext = 32'd0;
      case (w_fop)
         OP_LW:   w_ext = w_fword;
         OP_LH:   w_ext = {{16{w_lane_h[15]}}, w_lane_h};
         OP_LHU:  w_ext = {16'd0, w_lane_h};
         OP_LB:   w_ext = {{24{w_lane_b[7]}}, w_lane_b};
         OP_LBU:  w_ext = {24'd0, w_lane_b};
         default: w_ext = 32'd0;
      endcase
      if (!w_fv || w_fexc) w_ext = 32'd0;
   end

   assign bus.req_ready = w_ready;
   assign bus.init_done = w_init_done;
   assign bus.rsp_valid = w_fv;
   assign bus.rsp_data  = w_ext;
   assign bus.rsp_exc   = w_fv & w_fexc;
   assign bus.st_exc    = r_st_exc;

`ifdef DM_DISPLAY_EN
   logic [31:0] w_dbg_word;

   always_comb begin
      for (int b = 0; b < 4; b++) begin
         w_dbg_word[8*b +: 8] = w_be[b] ? w_st_data[8*b +: 8] : r_mem[w_idx][8*b +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (w_st_commit)
         $display("@%08h: *%08h <= %08h", bus.req_pc, {w_addr[AW-1:2], 2'b00}, w_dbg_word);
   end
`else
   logic w_unused_pc;
   assign w_unused_pc = ^bus.req_pc;
`endif
endmodule

// File: tb/tb_dm_ctrl.sv
// tb/tb_dm_ctrl.sv - directed self-checking bench for dm_ctrl (DEPTH=16, RD_LAT=2)
module tb_dm_ctrl;
   localparam int DEPTH = 16;
   localparam int LAT   = 2;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   logic        v, e, se;
   logic [31:0] d;

   dm_ctrl_if #(.AW(32)) bus ();

   dm_ctrl #(.DEPTH(DEPTH), .AW(32), .RD_LAT(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_load(input logic [2:0] op, input logic [31:0] addr,
                          output logic ov, output logic [31:0] od, output logic oe);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_addr  = addr;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      repeat (LAT - 1) begin @(posedge clk); #1; end
      ov = bus.rsp_valid;
      od = bus.rsp_data;
      oe = bus.rsp_exc;
   endtask

   task automatic do_store(input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic oexc);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_pc    = 32'h0040_0000 + addr;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      oexc = bus.st_exc;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
      total++; if (bus.rsp_data !== 32'd0) begin bad++; $display("FAIL reset_rsp_data got %h want 0", bus.rsp_data); end
      total++; if (bus.rsp_exc !== 1'b0) begin bad++; $display("FAIL reset_rsp_exc got %b want 0", bus.rsp_exc); end
      total++; if (bus.st_exc !== 1'b0) begin bad++; $display("FAIL reset_st_exc got %b want 0", bus.st_exc); end
      for (int i = 0; i < DEPTH; i++) begin
         total++;
         if ({bus.init_done, bus.req_ready} !== 2'b00) begin
            bad++; $display("FAIL sweep_busy cycle %0d got %b want 00", i + 1, {bus.init_done, bus.req_ready});
         end
         @(posedge clk); #1;
      end
      total++; if ({bus.init_done, bus.req_ready} !== 2'b11) begin bad++; $display("FAIL sweep_done got %b want 11", {bus.init_done, bus.req_ready}); end
      do_load(3'd0, 32'h3C, v, d, e);
      total++; if ({v, e, d} !== {1'b1, 1'b0, 32'h0}) begin bad++; $display("FAIL lw_3c_zero got v=%b e=%b d=%h want v=1 e=0 d=0", v, e, d); end
   endtask

   task automatic test_merge();
      do_store(3'd5, 32'h10, 32'h1122_3344, se);
      total++; if (se !== 1'b0) begin bad++; $display("FAIL merge_sw_exc got %b want 0", se); end
      do_store(3'd7, 32'h13, 32'h0000_00AA, se);
      total++; if (se !== 1'b0) begin bad++; $display("FAIL merge_sb_exc got %b want 0", se); end
      do_store(3'd6, 32'h10, 32'h0000_BEEF, se);
      total++; if (se !== 1'b0) begin bad++; $display("FAIL merge_sh_exc got %b want 0", se); end
      do_load(3'd0, 32'h10, v, d, e);
      total++; if ({v, e, d} !== {1'b1, 1'b0, 32'hAA22_BEEF}) begin bad++; $display("FAIL merge_lw got v=%b e=%b d=%h want v=1 e=0 d=aa22beef", v, e, d); end
   endtask

   task automatic test_extension();
      logic [2:0]  ops  [7];
      logic [31:0] adrs [7];
      logic [31:0] exps [7];
      ops  = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
      adrs = '{32'h12, 32'h13, 32'h12, 32'h10, 32'h13, 32'h11, 32'h10};
      exps = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01,
               32'hFFFF_FF80, 32'h0000_007F, 32'h0000_7F01};
      do_store(3'd5, 32'h10, 32'h80FF_7F01, se);
      for (int i = 0; i < 7; i++) begin
         do_load(ops[i], adrs[i], v, d, e);
         total++;
         if ({v, e, d} !== {1'b1, 1'b0, exps[i]}) begin
            bad++; $display("FAIL ext op=%0d addr=%h got v=%b e=%b d=%h want v=1 e=0 d=%h", ops[i], adrs[i], v, e, d, exps[i]);
         end
      end
   endtask

   task automatic test_exceptions();
      do_load(3'd0, 32'h11, v, d, e);
      total++; if ({v, e, d} !== {1'b1, 1'b1, 32'h0}) begin bad++; $display("FAIL lw_misalign got v=%b e=%b d=%h want v=1 e=1 d=0", v, e, d); end
      do_store(3'd6, 32'h13, 32'h0000_1234, se);
      total++; if (se !== 1'b1) begin bad++; $display("FAIL sh_misalign_exc got %b want 1", se); end
      @(posedge clk); #1;
      total++; if (bus.st_exc !== 1'b0) begin bad++; $display("FAIL st_exc_pulse got %b want 0", bus.st_exc); end
      do_load(3'd0, 32'h10, v, d, e);
      total++; if ({v, e, d} !== {1'b1, 1'b0, 32'h80FF_7F01}) begin bad++; $display("FAIL sh_misalign_nowrite got d=%h want 80ff7f01", d); end
      do_store(3'd5, 32'(4 * DEPTH), 32'hDEAD_BEEF, se);
      total++; if (se !== 1'b1) begin bad++; $display("FAIL sw_range_exc got %b want 1", se); end
      do_load(3'd0, 32'(4 * DEPTH), v, d, e);
      total++; if ({v, e, d} !== {1'b1, 1'b1, 32'h0}) begin bad++; $display("FAIL lw_range got v=%b e=%b d=%h want v=1 e=1 d=0", v, e, d); end
      do_store(3'd5, 32'h3C, 32'h1234_5678, se);
      total++; if (se !== 1'b0) begin bad++; $display("FAIL sw_last_word_exc got %b want 0", se); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] words [4];
      words = '{32'h1000_0001, 32'h2000_0002, 32'h3000_0003, 32'h4000_0004};
      for (int i = 0; i < 4; i++) do_store(3'd5, 32'(4 * i), words[i], se);
      @(posedge clk); #1;
      for (int c = 0; c < 7; c++) begin
         total++;
         if (bus.rsp_valid !== ((c >= 2) && (c <= 5))) begin
            bad++; $display("FAIL pipe_valid cycle t+%0d got %b", c, bus.rsp_valid);
         end
         if (c >= 2 && c <= 5) begin
            total++;
            if (bus.rsp_data !== words[c-2]) begin
               bad++; $display("FAIL pipe_data cycle t+%0d got %h want %h", c, bus.rsp_data, words[c-2]);
            end
         end
         bus.req_valid = (c < 4);
         bus.req_op    = 3'd0;
         bus.req_addr  = 32'(4 * c);
         @(posedge clk); #1;
      end
      bus.req_valid = 1'b0;
      do_store(3'd5, 32'h8, 32'hCAFE_F00D, se);
      do_load(3'd0, 32'h8, v, d, e);
      total++; if ({v, e, d} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin bad++; $display("FAIL store_then_load got v=%b e=%b d=%h want cafef00d", v, e, d); end
   endtask

   task automatic test_reset_mid();
      int seen;
      int waited;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      total++; if (bus.init_done !== 1'b0) begin bad++; $display("FAIL mid_sweep_busy got %b want 0", bus.init_done); end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         total++;
         if (bus.init_done !== 1'b0) begin bad++; $display("FAIL restart_busy cycle %0d got %b want 0", i + 1, bus.init_done); end
         @(posedge clk); #1;
      end
      total++; if (bus.init_done !== 1'b1) begin bad++; $display("FAIL restart_done got %b want 1", bus.init_done); end
      do_load(3'd0, 32'h10, v, d, e);
      total++; if ({v, e, d} !== {1'b1, 1'b0, 32'h0}) begin bad++; $display("FAIL restart_cleared got d=%h want 0", d); end

      bus.req_valid = 1'b1;
      bus.req_op    = 3'd0;
      bus.req_addr  = 32'h3C;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      reset = 1'b1;
      seen = 0;
      if (bus.rsp_valid === 1'b1) seen++;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.rsp_valid === 1'b1) seen++;
         @(posedge clk); #1;
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL inflight_dropped got %0d pulses want 0", seen); end
      waited = 0;
      while (bus.init_done !== 1'b1 && waited < 40) begin
         @(posedge clk); #1;
         waited++;
      end
      total++; if (bus.init_done !== 1'b1) begin bad++; $display("FAIL inflight_reinit got %b want 1", bus.init_done); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_op    = 3'd0;
      bus.req_addr  = 32'd0;
      bus.req_wdata = 32'd0;
      bus.req_pc    = 32'd0;
      test_reset();
      test_merge();
      test_extension();
      test_exceptions();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
